div_unit: RTL and testbench

- Iterative radix-2 restoring divider for the RV32M divide group: DIV, DIVU, REM and REMU.
- It is the counterpart of the core's iterative multiplier and sits in the EXE stage of the out-of-order core.
- Each accepted operation is tagged with its ROB index, and that tag is returned with the result.
- One operation is in flight at a time. Issue must not send a new operation while busy is high.

---
 rtl/div_unit.sv | 188 ++++++++++++++++++
 tb/tb_div_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the RV32M divide group
// (DIV, DIVU, REM, REMU). One operation in flight; the result is
// returned with the ROB tag captured at acceptance.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for div_start; fast-path cases are resolved here
// CALC  | one quotient bit per cycle, r_cnt runs 0..31
// DONE  | div_o_valid strobe for one cycle, then back to IDLE
module div_unit #(
   parameter int ROB_IDX_W = 3,
   parameter int XLEN      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 div_start,
   input  logic [2:0]           funct3,
   input  logic [XLEN-1:0]      rs1_data,
   input  logic [XLEN-1:0]      rs2_data,
   input  logic [ROB_IDX_W-1:0] exe_rob_idx,
   input  logic                 flush,
   output logic                 div_busy,
   output logic [XLEN-1:0]      div_out,
   output logic [ROB_IDX_W-1:0] div_rob_idx,
   output logic                 div_o_valid
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [4:0]            r_cnt;
   logic [XLEN-1:0]       r_quo;
   logic [XLEN-1:0]       r_rem;
   logic [XLEN-1:0]       r_dvsr;
   logic                  r_neg_q;
   logic                  r_neg_r;
   logic                  r_is_rem;
   logic                  r_is_signed;
   logic [ROB_IDX_W-1:0]  r_tag;
   logic [XLEN-1:0]       r_out;
   logic [ROB_IDX_W-1:0]  r_out_tag;

   logic                  w_accept;
   logic                  w_signed;
   logic                  w_a_neg;
   logic                  w_b_neg;
   logic [XLEN-1:0]       w_a_mag;
   logic [XLEN-1:0]       w_b_mag;
   logic                  w_fast;
   logic [XLEN-1:0]       w_fast_val;

   logic [XLEN:0]         w_shift;
   logic [XLEN:0]         w_trial;
   logic [XLEN-1:0]       w_rem_nxt;
   logic [XLEN-1:0]       w_quo_nxt;
   logic [XLEN-1:0]       w_raw;
   logic                  w_neg_res;
   logic [XLEN-1:0]       w_result;
   logic                  w_last;

   // Acceptance and operand preparation: magnitudes for signed ops.
   always_comb begin
      w_accept = (r_state == S_IDLE) && div_start && !flush;
      w_signed = !funct3[0];
      w_a_neg  = w_signed && rs1_data[XLEN-1];
      w_b_neg  = w_signed && rs2_data[XLEN-1];
      w_a_mag  = w_a_neg ? (~rs1_data + {{(XLEN-1){1'b0}}, 1'b1}) : rs1_data;
      w_b_mag  = w_b_neg ? (~rs2_data + {{(XLEN-1){1'b0}}, 1'b1}) : rs2_data;
   end

   // Fast-path detection: non-divide funct3, divide by zero, signed overflow.
   always_comb begin
      w_fast     = 1'b1;
      w_fast_val = '0;
      if (!funct3[2]) begin
         w_fast_val = '0;
      end else if (rs2_data == '0) begin
         w_fast_val = funct3[1] ? rs1_data : '1;
      end else if (w_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (rs2_data == '1)) begin
         w_fast_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end else begin
         w_fast = 1'b0;
      end
   end

   // One restoring step; the trial is one bit wider so that a partial
   // remainder above 2^31 (unsigned ops) still compares correctly.
   always_comb begin
      w_shift   = {r_rem, r_quo[XLEN-1]};
      w_trial   = w_shift - {1'b0, r_dvsr};
      w_rem_nxt = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
      w_quo_nxt = {r_quo[XLEN-2:0], ~w_trial[XLEN]};
      w_raw     = r_is_rem ? w_rem_nxt : w_quo_nxt;
      w_neg_res = r_is_signed && (r_is_rem ? r_neg_r : r_neg_q);
      w_result  = w_neg_res ? (~w_raw + {{(XLEN-1){1'b0}}, 1'b1}) : w_raw;
      w_last    = (r_cnt == 5'd31);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_fast ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (flush) begin
         w_state_nxt = S_IDLE;
      end
   end

   // Outputs: strobe suppressed under flush, result registers held.
   always_comb begin
      div_busy    = (r_state != S_IDLE);
      div_o_valid = (r_state == S_DONE) && !flush;
      div_out     = r_out;
      div_rob_idx = r_out_tag;
   end

   // Datapath: operand capture, iteration, result write on entry to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_quo       <= '0;
         r_rem       <= '0;
         r_dvsr      <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_is_rem    <= 1'b0;
         r_is_signed <= 1'b0;
         r_tag       <= '0;
         r_out       <= '0;
         r_out_tag   <= '0;
      end else if (w_accept) begin
         r_cnt       <= '0;
         r_quo       <= w_a_mag;
         r_rem       <= '0;
         r_dvsr      <= w_b_mag;
         r_neg_q     <= rs1_data[XLEN-1] ^ rs2_data[XLEN-1];
         r_neg_r     <= rs1_data[XLEN-1];
         r_is_rem    <= funct3[1];
         r_is_signed <= w_signed;
         r_tag       <= exe_rob_idx;
         if (w_fast) begin
            r_out     <= w_fast_val;
            r_out_tag <= exe_rob_idx;
         end
      end else if ((r_state == S_CALC) && !flush) begin
         r_cnt <= r_cnt + 5'd1;
         r_quo <= w_quo_nxt;
         r_rem <= w_rem_nxt;
         if (w_last) begin
            r_out     <= w_result;
            r_out_tag <= r_tag;
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a per-cycle compare against an
// arithmetic reference model of the RV32M divide group.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        div_start = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic [2:0]  exe_rob_idx = '0;
   logic        flush = 1'b0;
   logic        div_busy;
   logic [31:0] div_out;
   logic [2:0]  div_rob_idx;
   logic        div_o_valid;

   div_unit #(.ROB_IDX_W(3), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .div_start(div_start), .funct3(funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .exe_rob_idx(exe_rob_idx),
      .flush(flush), .div_busy(div_busy), .div_out(div_out),
      .div_rob_idx(div_rob_idx), .div_o_valid(div_o_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Expectation state written only by the stimulus process.
   int          m_busy_from = 1;
   int          m_busy_to   = 0;
   int          m_valid_cyc = -1;
   int          m_out_cyc   = -1;
   int          m_rst_cyc   = -1;
   logic [31:0] m_exp_out   = '0;
   logic [2:0]  m_exp_tag   = '0;
   logic        chk_en      = 1'b0;

   // Held-output model owned by the compare process.
   logic [31:0] m_out = '0;
   logic [2:0]  m_tag = '0;

   localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101,
                          F_REM = 3'b110, F_REMU = 3'b111;

   function automatic logic [31:0] model(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic               ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (!f[2]) return 32'd0;
      case (f[1:0])
         2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
         2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'b10:   return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
      if (!f[2] || b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_valid, exp_busy;
         if (cyc == m_rst_cyc) begin
            m_out = '0;
            m_tag = '0;
         end
         if (cyc == m_out_cyc) begin
            m_out = m_exp_out;
            m_tag = m_exp_tag;
         end
         exp_valid = (cyc == m_valid_cyc);
         exp_busy  = (cyc >= m_busy_from) && (cyc <= m_busy_to);
         checks += 4;
         if (div_o_valid !== exp_valid) begin
            errors++;
            $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, div_o_valid, exp_valid);
         end
         if (div_busy !== exp_busy) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, div_busy, exp_busy);
         end
         if (div_out !== m_out) begin
            errors++;
            $display("FAIL out cyc=%0d got=%h exp=%h", cyc, div_out, m_out);
         end
         if (div_rob_idx !== m_tag) begin
            errors++;
            $display("FAIL tag cyc=%0d got=%0d exp=%0d", cyc, div_rob_idx, m_tag);
         end
      end
   end

   // Called at posedge+1 of the issue cycle T; returns at posedge+1 of T+1.
   task automatic issue(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] tag,
                        input logic [31:0] lit, input int lat,
                        output int t);
      logic [31:0] mv;
      int          ml;
      mv = model(f, a, b);
      ml = model_lat(f, a, b);
      checks++;
      if (mv !== lit || ml != lat) begin
         errors++;
         $display("FAIL model f=%b a=%h b=%h got=%h/%0d exp=%h/%0d", f, a, b, mv, ml, lit, lat);
      end
      t           = cyc;
      funct3      = f;
      rs1_data    = a;
      rs2_data    = b;
      exe_rob_idx = tag;
      div_start   = 1'b1;
      m_exp_out   = lit;
      m_exp_tag   = tag;
      m_busy_from = t + 1;
      m_busy_to   = t + lat;
      m_valid_cyc = t + lat;
      m_out_cyc   = t + lat;
      @(posedge clk); #1;
      div_start   = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (cyc <= m_busy_to && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL timeout cyc=%0d", cyc);
      end
      @(posedge clk); #1;
   endtask

   task automatic run(input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] tag,
                      input logic [31:0] lit, input int lat);
      int t;
      issue(f, a, b, tag, lit, lat, t);
      wait_idle();
   endtask

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); #1;

      run(F_DIV,  32'd100,       32'd7,         3'd3, 32'd14,        33);
      run(F_REM,  32'hFFFF_FF9C, 32'd7,         3'd1, 32'hFFFF_FFFE, 33);
      run(F_DIV,  32'hFFFF_FF9C, 32'd7,         3'd2, 32'hFFFF_FFF2, 33);
      run(F_DIVU, 32'hFFFF_FFFF, 32'd2,         3'd4, 32'h7FFF_FFFF, 33);
      run(F_REMU, 32'hFFFF_FFFF, 32'd2,         3'd5, 32'd1,         33);
      run(F_DIV,  32'd7,         32'hFFFF_FFFE, 3'd6, 32'hFFFF_FFFD, 33);
      run(F_REM,  32'd7,         32'hFFFF_FFFE, 3'd7, 32'd1,         33);
      run(F_DIVU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'd1, 32'd0,         33);
      run(F_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'd2, 32'hFFFF_FFFE, 33);
      run(F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 3'd3, 32'h8000_0000, 33);
      run(F_DIV,  32'd5,         32'd0,         3'd4, 32'hFFFF_FFFF, 1);
      run(F_REMU, 32'd5,         32'd0,         3'd5, 32'd5,         1);
      run(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 32'h8000_0000, 1);
      run(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 3'd7, 32'd0,         1);
      run(3'b000, 32'd12,        32'd3,         3'd2, 32'd0,         1);

      // Start while busy is ignored.
      issue(F_DIV, 32'd1000, 32'd10, 3'd5, 32'd100, 33, t);
      repeat (4) begin @(posedge clk); #1; end
      funct3 = F_DIVU; rs1_data = 32'd1; rs2_data = 32'd1; exe_rob_idx = 3'd2;
      div_start = 1'b1;
      @(posedge clk); #1;
      div_start = 1'b0;
      wait_idle();

      // Start together with flush in IDLE is not accepted.
      funct3 = F_DIV; rs1_data = 32'd8; rs2_data = 32'd2; exe_rob_idx = 3'd1;
      div_start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      div_start = 1'b0; flush = 1'b0;
      @(posedge clk); #1;

      // Flush at T+10, then a new op accepted at T+11.
      issue(F_DIV, 32'd1000, 32'd10, 3'd4, 32'd100, 33, t);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      m_busy_to = cyc; m_valid_cyc = -1; m_out_cyc = -1;
      @(posedge clk); #1;
      flush = 1'b0;
      issue(F_DIV, 32'd9, 32'd3, 3'd6, 32'd3, 33, t);
      wait_idle();

      // Flush during DONE suppresses the strobe; the result stays written.
      issue(F_DIVU, 32'd7, 32'd0, 3'd3, 32'hFFFF_FFFF, 1, t);
      flush = 1'b1;
      m_valid_cyc = -1;
      @(posedge clk); #1;
      flush = 1'b0;
      wait_idle();

      // Reset at T+10 returns all outputs to zero at T+11.
      issue(F_REM, 32'd1000, 32'd7, 3'd5, 32'd6, 33, t);
      repeat (9) begin @(posedge clk); #1; end
      rst = 1'b1;
      m_busy_to = cyc; m_valid_cyc = -1; m_out_cyc = -1; m_rst_cyc = cyc + 1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      run(F_DIVU, 32'd50, 32'd6, 3'd7, 32'd8, 33);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
